comb_sub8: RTL and testbench
============================

Name: comb_sub8

Overview:
- Pipelined multi-stage comb (differentiator) section for the 8-bit datapath.
- Implements y[n] = x[n] - x[n-DELAY] per stage, the inverse of the integrating adder chain; together with that chain it forms a CIC decimator/interpolator.
- Sits after the rate-change point in the RX chain and runs on the DSP clock.
- Processes a sample only when its input strobe is high.

Parameters:
- WIDTH, 8: sample width in bits. All arithmetic is modulo 2^WIDTH, two's complement.
- STAGES, 3: number of cascaded comb stages. Legal range 1..6.
- DELAY, 1: differential delay M per stage. Legal values 1 or 2.

Ports:
- clock  in  1  DSP clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  synchronous run enable. Low clears all state.
- strobe_in  in  1  one-cycle qualifier; signal_in is valid when high.
- signal_in  in  WIDTH  input sample, two's complement.
- strobe_out  out  1  one-cycle qualifier; signal_out is new this cycle.
- signal_out  out  WIDTH  comb output, two's complement, wrapped.

Behaviour:
- Reset:
  - Asynchronous: reset high immediately forces all state to 0, including delay lines, stage registers and the strobe pipeline.
  - strobe_out=0 and signal_out=0 while reset is high and after release.
- Enable low, reset low:
  - On each clock edge, clear all state to 0, exactly as reset does.
  - Ignore strobe_in.
  - Processing resumes on the first edge where enable=1.
- Stage k (k=1..STAGES):
  - Input is stage k-1's register; stage 1's input is signal_in.
  - Input qualifier is st[k-1]; st[0]=strobe_in.
  - When st[k-1]=1 at the edge:
    - out_k <= in_k - dl_k[DELAY-1], modulo 2^WIDTH.
    - dl_k shifts: dl_k[0] <= in_k, dl_k[i] <= dl_k[i-1].
    - st[k] <= 1.
  - When st[k-1]=0: out_k and dl_k hold; st[k] <= 0.
- Outputs: signal_out = out_STAGES and strobe_out = st[STAGES], both registered with no combinational path from inputs.
- Latency: strobe_out asserts exactly STAGES clocks after the matching strobe_in. signal_out holds its value until the next strobe_out.
- Throughput: strobe_in may be high every cycle. Any gap pattern is legal; gaps do not advance the delay lines, so samples are counted by strobe, not by clock.
- Wrap-around: the subtraction uses no saturation and no widening. Bit growth must have been absorbed upstream; a preceding integrator chain with wrapped state is recovered exactly.
- Simultaneous events:
  - reset overrides enable and strobe.
  - enable=0 overrides strobe_in.
  - An in-flight sample present when enable drops or reset asserts is discarded; no strobe_out is emitted for it.
- Startup: the delay lines start at 0, so the first outputs after reset or enable equal the impulse/step transient of zero-initialised combs. No warm-up suppression.

Test Plan:
- Impulse, STAGES=3, DELAY=1:
  - Stimulus: strobe every cycle, signal_in = 0x01 then 0x00 repeated.
  - Required: strobe_out first high 3 clocks after the first strobe_in; signal_out sequence 0x01, 0xFD, 0x03, 0xFF, then 0x00 forever.
- Step, STAGES=3, DELAY=1:
  - Stimulus: constant 0x05.
  - Required: output 0x05, 0xF6, 0x05, then 0x00 steady.
- DELAY=2, STAGES=1:
  - Stimulus: ramp 0,1,2,...,0xFF,0x00,...
  - Required: output 0x00, 0x01, then 0x02 every strobe, including across the 0xFF->0x00 wrap.
- Gapped strobe:
  - Stimulus: impulse test with strobe_in high one cycle in four.
  - Required: identical value sequence to the impulse test; each strobe_out exactly 3 clocks after its strobe_in; signal_out stable between strobes.
- Round trip:
  - Stimulus: random 8-bit samples through a 3-stage wrapping accumulator model, then into the DUT (DELAY=1).
  - Required: DUT output equals the original samples after the transient, bit-exact over 10k samples.
- Enable / reset mid-stream:
  - Drop enable for 1 cycle during the impulse test: no strobe_out for the in-flight samples; the next impulse reproduces 0x01, 0xFD, 0x03, 0xFF.
  - Assert reset between clock edges: strobe_out and signal_out go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/comb_sub8.sv
// Cascaded comb (differentiator) section: y[n] = x[n] - x[n-DELAY] per stage,
// strobe-qualified, wrapping two's-complement arithmetic, registered outputs.
module comb_sub8 #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int DELAY  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             strobe_in,
    input  logic [WIDTH-1:0] signal_in,
    output logic             strobe_out,
    output logic [WIDTH-1:0] signal_out
);

    // Modulo-2^WIDTH difference; no widening, so wrapped integrator state is recovered exactly.
    function automatic logic [WIDTH-1:0] wrap_sub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return a - b;
    endfunction

    // Index 0 is the block input; index k is the registered output of stage k.
    logic [STAGES:0][WIDTH-1:0] data_s;
    logic [STAGES:0]            vld_s;

    assign data_s[0] = signal_in;
    assign vld_s[0]  = strobe_in;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0]       out_q;
        logic [WIDTH-1:0]       out_d;
        logic [DELAY*WIDTH-1:0] dl_q;
        logic [DELAY*WIDTH-1:0] dl_d;
        logic                   st_q;
        logic                   st_d;

        // Next-state: clear on enable low, advance only on a qualified sample, else hold.
        always_comb begin
            out_d = out_q;
            dl_d  = dl_q;
            st_d  = 1'b0;
            if (!enable) begin
                out_d = {WIDTH{1'b0}};
                dl_d  = {(DELAY*WIDTH){1'b0}};
                st_d  = 1'b0;
            end else if (vld_s[g]) begin
                out_d             = wrap_sub(data_s[g], dl_q[DELAY*WIDTH-1 -: WIDTH]);
                dl_d              = dl_q << WIDTH;
                dl_d[WIDTH-1:0]   = data_s[g];
                st_d              = 1'b1;
            end else begin
                out_d = out_q;
                dl_d  = dl_q;
                st_d  = 1'b0;
            end
        end

        // Stage state register with asynchronous clear.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                out_q <= {WIDTH{1'b0}};
                dl_q  <= {(DELAY*WIDTH){1'b0}};
                st_q  <= 1'b0;
            end else begin
                out_q <= out_d;
                dl_q  <= dl_d;
                st_q  <= st_d;
            end
        end

        assign data_s[g+1] = out_q;
        assign vld_s[g+1]  = st_q;
    end

    assign signal_out = data_s[STAGES];
    assign strobe_out = vld_s[STAGES];

endmodule

// File: tb/tb_comb_sub8.sv
// Directed bench for comb_sub8: table vectors (impulse, step, gapped, enable drop)
// plus hand sequences for DELAY=2 ramp, integrator round trip and async reset.
module tb_comb_sub8;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       strobe_in, strobe_in2;
    logic [7:0] signal_in, signal_in2;
    logic       strobe_out, strobe_out2;
    logic [7:0] signal_out, signal_out2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    comb_sub8 #(.WIDTH(8), .STAGES(3), .DELAY(1)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .strobe_in(strobe_in), .signal_in(signal_in),
        .strobe_out(strobe_out), .signal_out(signal_out)
    );

    comb_sub8 #(.WIDTH(8), .STAGES(1), .DELAY(2)) dut2 (
        .clock(clock), .reset(reset), .enable(enable),
        .strobe_in(strobe_in2), .signal_in(signal_in2),
        .strobe_out(strobe_out2), .signal_out(signal_out2)
    );

    typedef struct {
        logic       en;
        logic       stb;
        logic [7:0] din;
        logic       exp_stb;
        logic [7:0] exp_dout;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic stb, input logic [7:0] din,
                       input logic estb, input logic [7:0] edout, input string tag);
        vec_t v;
        v.en = en; v.stb = stb; v.din = din;
        v.exp_stb = estb; v.exp_dout = edout; v.tag = tag;
        tbl.push_back(v);
    endtask

    function automatic logic [7:0] imp_resp(input int k);
        case (k)
            0:       return 8'h01;
            1:       return 8'hFD;
            2:       return 8'h03;
            3:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] step_resp(input int k);
        case (k)
            0:       return 8'h05;
            1:       return 8'hF6;
            2:       return 8'h05;
            default: return 8'h00;
        endcase
    endfunction

    // Watchdog: the bench must end by itself even if something stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a1, a2, a3, x;
        logic [7:0] q[$];
        int         sent, drain;

        reset = 1'b1; enable = 1'b0;
        strobe_in = 1'b0; signal_in = 8'h00;
        strobe_in2 = 1'b0; signal_in2 = 8'h00;

        // Impulse, strobe every cycle.
        for (int i = 0; i < 9; i++)
            add(1'b1, 1'b1, (i == 0) ? 8'h01 : 8'h00, i >= 2,
                (i < 2) ? 8'h00 : imp_resp(i - 2), "impulse");
        add(1'b0, 1'b1, 8'h55, 1'b0, 8'h00, "clear1");
        // Step of 0x05.
        for (int i = 0; i < 8; i++)
            add(1'b1, 1'b1, 8'h05, i >= 2,
                (i < 2) ? 8'h00 : step_resp(i - 2), "step");
        add(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "clear2");
        // Impulse with strobe one cycle in four; output held between strobes.
        for (int i = 0; i < 24; i++)
            add(1'b1, (i % 4) == 0, (i == 0) ? 8'h01 : 8'h00, (i % 4) == 2,
                (i < 2) ? 8'h00 : imp_resp((i - 2) / 4), "gapped");
        add(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "clear3");
        // Enable drops for one cycle with samples in flight.
        add(1'b1, 1'b1, 8'h01, 1'b0, 8'h00, "endrop");
        add(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, "endrop");
        add(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, "endrop");
        add(1'b1, 1'b1, 8'h01, 1'b0, 8'h00, "endrop");
        add(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, "endrop");
        for (int i = 0; i < 5; i++)
            add(1'b1, 1'b1, 8'h00, 1'b1, imp_resp(i), "endrop");

        // Reset state, then enable still low after release.
        @(posedge clock); @(posedge clock); #1;
        chk1("reset_stb", strobe_out, 1'b0);
        chk8("reset_dout", signal_out, 8'h00);
        reset = 1'b0;
        @(posedge clock); #1;
        chk1("post_reset_stb", strobe_out, 1'b0);
        chk8("post_reset_dout", signal_out, 8'h00);

        foreach (tbl[i]) begin
            enable    = tbl[i].en;
            strobe_in = tbl[i].stb;
            signal_in = tbl[i].din;
            @(posedge clock); #1;
            chk1($sformatf("%s[%0d].stb", tbl[i].tag, i), strobe_out, tbl[i].exp_stb);
            chk8($sformatf("%s[%0d].dout", tbl[i].tag, i), signal_out, tbl[i].exp_dout);
        end

        // DELAY=2, single stage: ramp gives 0, 1, then 2 through the 0xFF->0x00 wrap.
        strobe_in = 1'b0; enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            strobe_in2 = 1'b1;
            signal_in2 = i[7:0];
            @(posedge clock); #1;
            chk1($sformatf("ramp[%0d].stb", i), strobe_out2, 1'b1);
            chk8($sformatf("ramp[%0d].dout", i), signal_out2,
                 (i == 0) ? 8'h00 : ((i == 1) ? 8'h01 : 8'h02));
        end
        strobe_in2 = 1'b0;

        // Round trip through a wrapping 3-stage integrator model with random gaps.
        enable = 1'b0;
        @(posedge clock); #1;
        enable = 1'b1;
        a1 = 8'h00; a2 = 8'h00; a3 = 8'h00;
        sent = 0; drain = 0;
        while (sent < 10000 || (q.size() > 0 && drain < 20)) begin
            if (sent < 10000 && $urandom_range(0, 3) != 0) begin
                x  = 8'($urandom);
                a1 = a1 + x;
                a2 = a2 + a1;
                a3 = a3 + a2;
                strobe_in = 1'b1;
                signal_in = a3;
                q.push_back(x);
                sent++;
            end else begin
                strobe_in = 1'b0;
                signal_in = 8'($urandom);
                if (sent >= 10000) drain++;
            end
            @(posedge clock); #1;
            if (strobe_out) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL roundtrip_extra: got strobe_out with value %02h, expected no output", signal_out);
                end else begin
                    chk8($sformatf("roundtrip[%0d]", sent), signal_out, q.pop_front());
                end
            end
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL roundtrip_drain: got %0d samples outstanding, expected 0", q.size());
        end

        // Asynchronous reset between clock edges while an output is live.
        strobe_in = 1'b0;
        enable = 1'b0;
        @(posedge clock); #1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe_in = 1'b1;
            signal_in = (i == 0) ? 8'h01 : 8'h00;
            @(posedge clock); #1;
        end
        chk1("pre_async_stb", strobe_out, 1'b1);
        chk8("pre_async_dout", signal_out, 8'hFD);
        #2 reset = 1'b1;
        #1;
        chk1("async_reset_stb", strobe_out, 1'b0);
        chk8("async_reset_dout", signal_out, 8'h00);
        @(posedge clock); #1;
        chk1("reset_hold_stb", strobe_out, 1'b0);
        chk8("reset_hold_dout", signal_out, 8'h00);
        reset = 1'b0;
        strobe_in = 1'b0;
        @(posedge clock); #1;
        chk1("release_stb", strobe_out, 1'b0);
        chk8("release_dout", signal_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
